// File: rtl/dcache_sa_wb.sv
// N-way set-associative write-back/write-allocate data cache with true-LRU and whole-cache flush.
// Hits respond one cycle after acceptance. Misses wait on the per-word memory valid/ack handshake, and req_ready stays low until the cache returns to idle.
module dcache_sa_wb #(
    parameter int WAYS       = 4,
    parameter int SETS       = 256,
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 32
) (
    input  logic              CLK,
    input  logic              RST_X,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    input  logic              flush_req,
    output logic              flush_done,
    output logic              mem_valid,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
);

    localparam int WAY_W = $clog2(WAYS);
    localparam int IDX_B = $clog2(SETS);
    localparam int IDX_W = (IDX_B > 0) ? IDX_B : 1;
    localparam int OFF_B = $clog2(LINE_WORDS);
    localparam int WO_W  = (OFF_B > 0) ? OFF_B : 1;
    localparam int BO    = OFF_B + 2;
    localparam int TAG_W = ADDR_W - BO - IDX_B;
    localparam int LA_W  = WAY_W + IDX_W;
    localparam int DA_W  = LA_W + WO_W;
    localparam logic [WO_W-1:0] LAST_OFF = WO_W'(LINE_WORDS - 1);

    typedef enum logic [2:0] {S_IDLE, S_WB, S_FILL, S_DONE, S_FLUSH} state_t;

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wdata;
    } req_t;

    function automatic logic [WO_W-1:0] f_off(input logic [ADDR_W-1:0] a);
        return WO_W'((a >> 2) & ADDR_W'(LINE_WORDS - 1));
    endfunction

    function automatic logic [IDX_W-1:0] f_idx(input logic [ADDR_W-1:0] a);
        return IDX_W'((a >> BO) & ADDR_W'(SETS - 1));
    endfunction

    function automatic logic [TAG_W-1:0] f_tag(input logic [ADDR_W-1:0] a);
        return TAG_W'(a >> (BO + IDX_B));
    endfunction

    function automatic logic [ADDR_W-1:0] f_addr(input logic [TAG_W-1:0] t,
                                                 input logic [IDX_W-1:0] i,
                                                 input logic [WO_W-1:0]  o);
        return (ADDR_W'(t) << (BO + IDX_B)) | (ADDR_W'(i) << BO) | (ADDR_W'(o) << 2);
    endfunction

    function automatic logic [LA_W-1:0] f_la(input logic [WAY_W-1:0] w, input logic [IDX_W-1:0] i);
        return {w, i};
    endfunction

    function automatic logic [DA_W-1:0] f_da(input logic [WAY_W-1:0] w, input logic [IDX_W-1:0] i,
                                             input logic [WO_W-1:0] o);
        return {w, i, o};
    endfunction

    state_t              state_q, state_d;
    req_t                req_q, req_d;
    logic [WAY_W-1:0]    way_q, way_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [WO_W-1:0]     cnt_q, cnt_d;
    logic                mem_valid_q, mem_valid_d;
    logic                mem_write_q, mem_write_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic                resp_valid_q, resp_valid_d;
    logic [31:0]         resp_rdata_q, resp_rdata_d;
    logic                flush_done_q, flush_done_d;
    logic [31:0]         hit_cnt_q, hit_cnt_d;
    logic [31:0]         miss_cnt_q, miss_cnt_d;

    logic [31:0]         data_q [2**DA_W];
    logic [TAG_W-1:0]    tag_q  [2**LA_W];
    logic [2**LA_W-1:0]  valid_q, dirty_q;
    logic [WAY_W-1:0]    age_q  [2**IDX_W][WAYS];

    logic [TAG_W-1:0]    r_tag;
    logic [IDX_W-1:0]    r_idx;
    logic [WO_W-1:0]     r_off;
    logic                hit, found_inv, vict_dirty, line_dirty, last_beat;
    logic [WAY_W-1:0]    hit_way, vict_way;

    logic                dwr_en, line_fill, dset_en, dclr_en, lru_en;
    logic [DA_W-1:0]     dwr_idx;
    logic [31:0]         dwr_dat;
    logic [LA_W-1:0]     dset_idx;
    logic [WAY_W-1:0]    lru_way;
    logic [IDX_W-1:0]    lru_idx;
    logic                burst, burst_wr, advance;
    logic [WO_W-1:0]     issue_off;

    assign r_tag = f_tag(req_addr);
    assign r_idx = f_idx(req_addr);
    assign r_off = f_off(req_addr);

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[f_la(WAY_W'(w), r_idx)] && tag_q[f_la(WAY_W'(w), r_idx)] == r_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Prefer the lowest invalid way; otherwise the oldest line in the set.
    always_comb begin
        vict_way  = '0;
        found_inv = 1'b0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[f_la(WAY_W'(w), r_idx)]) begin
                vict_way  = WAY_W'(w);
                found_inv = 1'b1;
            end
        end
        if (!found_inv) begin
            for (int w = 0; w < WAYS; w++) begin
                if (age_q[r_idx][w] == WAY_W'(WAYS - 1)) vict_way = WAY_W'(w);
            end
        end
    end

    assign vict_dirty = valid_q[f_la(vict_way, r_idx)] && dirty_q[f_la(vict_way, r_idx)];
    assign line_dirty = valid_q[f_la(way_q, idx_q)] && dirty_q[f_la(way_q, idx_q)];
    assign last_beat  = mem_valid_q && mem_ack && (cnt_q == LAST_OFF);

    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        way_d        = way_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        mem_valid_d  = mem_valid_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        flush_done_d = 1'b0;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        dwr_en       = 1'b0;
        dwr_idx      = f_da(way_q, idx_q, cnt_q);
        dwr_dat      = mem_rdata;
        line_fill    = 1'b0;
        dset_en      = 1'b0;
        dset_idx     = f_la(way_q, idx_q);
        dclr_en      = 1'b0;
        lru_en       = 1'b0;
        lru_way      = way_q;
        lru_idx      = idx_q;
        burst        = 1'b0;
        burst_wr     = 1'b0;
        advance      = 1'b0;
        issue_off    = mem_valid_q ? cnt_q + 1'b1 : cnt_q;

        case (state_q)
            S_IDLE: begin
                if (flush_req) begin
                    state_d = S_FLUSH;
                    way_d   = '0;
                    idx_d   = '0;
                    cnt_d   = '0;
                end else if (req_valid) begin
                    if (hit) begin
                        hit_cnt_d    = hit_cnt_q + 32'd1;
                        resp_valid_d = 1'b1;
                        lru_en       = 1'b1;
                        lru_way      = hit_way;
                        lru_idx      = r_idx;
                        if (req_write) begin
                            dwr_en       = 1'b1;
                            dwr_idx      = f_da(hit_way, r_idx, r_off);
                            dwr_dat      = req_wdata;
                            dset_en      = 1'b1;
                            dset_idx     = f_la(hit_way, r_idx);
                            resp_rdata_d = '0;
                        end else begin
                            resp_rdata_d = data_q[f_da(hit_way, r_idx, r_off)];
                        end
                    end else begin
                        miss_cnt_d = miss_cnt_q + 32'd1;
                        req_d      = '{wr: req_write, addr: req_addr, wdata: req_wdata};
                        way_d      = vict_way;
                        idx_d      = r_idx;
                        cnt_d      = '0;
                        state_d    = vict_dirty ? S_WB : S_FILL;
                    end
                end
            end
            S_WB: begin
                burst    = 1'b1;
                burst_wr = 1'b1;
                if (last_beat) state_d = S_FILL;
            end
            S_FILL: begin
                burst = 1'b1;
                if (mem_valid_q && mem_ack) dwr_en = 1'b1;
                if (last_beat) begin
                    line_fill = 1'b1;
                    lru_en    = 1'b1;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                resp_valid_d = 1'b1;
                state_d      = S_IDLE;
                if (req_q.wr) begin
                    dwr_en       = 1'b1;
                    dwr_idx      = f_da(way_q, idx_q, f_off(req_q.addr));
                    dwr_dat      = req_q.wdata;
                    dset_en      = 1'b1;
                    resp_rdata_d = '0;
                end else begin
                    resp_rdata_d = data_q[f_da(way_q, idx_q, f_off(req_q.addr))];
                end
            end
            S_FLUSH: begin
                if (line_dirty) begin
                    burst    = 1'b1;
                    burst_wr = 1'b1;
                    if (last_beat) begin
                        dclr_en = 1'b1;
                        advance = 1'b1;
                    end
                end else begin
                    advance = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Walk order is way-minor so each set is finished before moving on.
        if (advance) begin
            if (way_q == WAY_W'(WAYS - 1)) begin
                way_d = '0;
                if (idx_q == IDX_W'(SETS - 1)) begin
                    idx_d        = '0;
                    state_d      = S_IDLE;
                    flush_done_d = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end else begin
                way_d = way_q + 1'b1;
            end
        end

        if (burst) begin
            if (!mem_valid_q || (mem_ack && cnt_q != LAST_OFF)) begin
                mem_valid_d = 1'b1;
                mem_write_d = burst_wr;
                mem_addr_d  = f_addr(burst_wr ? tag_q[f_la(way_q, idx_q)] : f_tag(req_q.addr),
                                     idx_q, issue_off);
                mem_wdata_d = burst_wr ? data_q[f_da(way_q, idx_q, issue_off)] : '0;
                cnt_d       = issue_off;
            end else if (mem_ack) begin
                mem_valid_d = 1'b0;
                cnt_d       = '0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state_q      <= S_IDLE;
            req_q        <= '0;
            way_q        <= '0;
            idx_q        <= '0;
            cnt_q        <= '0;
            mem_valid_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            flush_done_q <= 1'b0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            way_q        <= way_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            mem_valid_q  <= mem_valid_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            flush_done_q <= flush_done_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            valid_q <= '0;
            dirty_q <= '0;
            for (int s = 0; s < 2**IDX_W; s++) begin
                for (int w = 0; w < WAYS; w++) age_q[s][w] <= WAY_W'(w);
            end
        end else begin
            if (line_fill) begin
                valid_q[f_la(way_q, idx_q)] <= 1'b1;
                dirty_q[f_la(way_q, idx_q)] <= 1'b0;
            end
            if (dset_en) dirty_q[dset_idx] <= 1'b1;
            if (dclr_en) dirty_q[f_la(way_q, idx_q)] <= 1'b0;
            if (lru_en) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (WAY_W'(w) == lru_way)
                        age_q[lru_idx][w] <= '0;
                    else if (age_q[lru_idx][w] < age_q[lru_idx][lru_way])
                        age_q[lru_idx][w] <= age_q[lru_idx][w] + 1'b1;
                end
            end
        end
    end

    // Payload arrays carry no reset; valid bits gate every use.
    always_ff @(posedge CLK) begin
        if (dwr_en) data_q[dwr_idx] <= dwr_dat;
        if (line_fill) tag_q[f_la(way_q, idx_q)] <= f_tag(req_q.addr);
    end

    assign req_ready  = (state_q == S_IDLE) && !flush_req;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign flush_done = flush_done_q;
    assign mem_valid  = mem_valid_q;
    assign mem_write  = mem_write_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign hit_cnt    = hit_cnt_q;
    assign miss_cnt   = miss_cnt_q;

endmodule

// File: doc/dcache_sa_wb.md
Name: dcache_sa_wb

Overview:
- Parametrised N-way set-associative data cache with multi-word lines, write-back/write-allocate policy, true-LRU replacement and a whole-cache flush.
- Sits between the MA stage and data main memory, replacing the fixed 4-way, 1-word-line, write-through cache and its hard-wired 7-cycle miss stall.
- Memory side uses a per-word valid/ack handshake, so miss latency is set by memory, not by a counter.

Parameters:
WAYS, 4, associativity (power of 2, >=2)
SETS, 256, sets per way (power of 2)
LINE_WORDS, 4, 32-bit words per line (power of 2, >=1)
ADDR_W, 32, byte-address width

Ports:
CLK  in  1  clock, rising edge
RST_X  in  1  asynchronous active-low reset
req_valid  in  1  CPU access request
req_write  in  1  1=store, 0=load
req_addr  in  ADDR_W  byte address; bits[1:0] ignored
req_wdata  in  32  store data
req_ready  out  1  cache can accept a request this cycle
resp_valid  out  1  one-cycle pulse: access complete
resp_rdata  out  32  load data, valid with resp_valid (0 for stores)
flush_req  in  1  pulse: write back all dirty lines
flush_done  out  1  one-cycle pulse when flush completes
mem_valid  out  1  memory word request
mem_write  out  1  1=write word, 0=read word
mem_addr  out  ADDR_W  word-aligned byte address
mem_wdata  out  32  write data
mem_ack  in  1  word accepted; read data valid this cycle
mem_rdata  in  32  read data
hit_cnt  out  32  hits since reset
miss_cnt  out  32  misses since reset

Behaviour:
- Address split: offset = log2(LINE_WORDS)+2 low bits; index = next log2(SETS) bits; tag = remainder.
- States: IDLE, WB, FILL, DONE, FLUSH.
- req_ready=1 only in IDLE with flush_req low. A request is accepted on req_valid&&req_ready and is latched.
- Hit in IDLE:
  - resp_valid/resp_rdata are registered and appear the next cycle.
  - A store updates the word and sets dirty.
  - hit_cnt increments.
  - Back-to-back hits sustain 1 per cycle.
- Miss in IDLE:
  - miss_cnt increments.
  - Victim selection: lowest-index invalid way; otherwise the way with age==WAYS-1.
  - Go to WB if the victim is valid&&dirty, else go to FILL.
- WB: issue LINE_WORDS word writes of the victim, offset 0 upward, at {victim tag, index, offset}. Then go to FILL.
- FILL:
  - Issue LINE_WORDS word reads, offset 0 upward; write each mem_rdata on mem_ack.
  - Then set tag, valid=1, dirty=0 and go to DONE.
- DONE:
  - Perform the latched access on the new line (store sets dirty).
  - Pulse resp_valid.
  - Return to IDLE.
- Memory handshake:
  - mem_valid/mem_write/mem_addr/mem_wdata are registered.
  - These outputs hold stable while mem_valid&&!mem_ack.
  - A word completes on the cycle mem_ack is high with mem_valid high; mem_ack is ignored when mem_valid=0.
  - The next word may be issued the following cycle.
- LRU:
  - Per-set age per way, width log2(WAYS).
  - On hit or fill-complete, the accessed way's age becomes 0; ways with age below its old age increment by 1.
  - Reset ages = way index.
- Flush:
  - flush_req in IDLE enters FLUSH; flush has priority over a simultaneous req_valid, which is not accepted.
  - FLUSH walks set 0..SETS-1, way 0..WAYS-1, writing back each valid dirty line (same order as WB) and clearing dirty.
  - Lines remain valid. Ages are unchanged.
  - flush_done pulses one cycle on returning to IDLE.
  - flush_req outside IDLE is ignored.
- Reset (asynchronous, any state, including mid-WB/FILL/FLUSH):
  - All valid, dirty and pending-request state clear immediately; state=IDLE.
  - Outputs: req_ready=1 (RST_X high), mem_valid=0, resp_valid=0, flush_done=0, counters=0.
  - The in-flight memory word is abandoned.
  - Data arrays need not reset.
- Counters wrap modulo 2^32.

Test Plan:
1. After reset, load 0x040 with mem returning 0x11,0x12,0x13,0x14 -> 4 reads at 0x040,0x044,0x048,0x04C; resp_rdata=0x11; then load 0x044 -> resp next cycle 0x12; hit_cnt=1, miss_cnt=1.
2. Store 0xDEAD to 0x044, then load 0x1040, 0x2040, 0x3040, 0x4040 (all set 4) -> the 0x4040 miss issues 4 writes to 0x040..0x04C with word 0x044=0xDEAD before 4 reads at 0x4040..0x404C.
3. Fill set 4 with tags of 0x040/0x1040/0x2040/0x3040, re-load 0x040, then load 0x4040 -> 0x1040 is evicted; a subsequent 0x040 load hits.
4. Dirty lines at 0x040 and 0x8F0, flush_req pulse -> exactly 8 mem writes; flush_done one pulse; a following load 0x040 hits with no mem traffic; a second flush -> 0 writes.
5. mem_ack delayed 3 cycles per word during FILL -> req_ready=0 throughout; mem_addr stable while unacked; resp_valid exactly one cycle after the 4th ack plus DONE.
6. Assert RST_X low mid-FILL between clock edges -> mem_valid drops without a clock edge; after release, load 0x040 misses again (miss_cnt=1).
